// File: rtl/map_layer.sv
// -----------------------------------------------------------------------------
// map_layer
//
// Tile/object map layer for a two-player VGA game. It holds a table of
// rectangle descriptors, finds the lowest-indexed rectangle under the current
// pixel, and emits the matching sprite-memory address two clocks later.
// A small IDLE/PLAY/CLEAR state machine tracks collectable gems and level
// completion.
//
// Optional feature macro: MAP_LAYER_GEM_EN
//   defined   -> gem collection, gem masking and the gem condition for CLEAR
//   undefined -> gem_touch ignored, gems_left = 0, CLEAR needs only exit_ok
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         layer enable (play runs only while high)
//   vga_h/v    VGA pixel coordinates; map coordinates are these >> 1
//   wr_en      table write strobe
//   wr_idx     table slot to write
//   wr_data    {valid, pivot_h, pivot_v, width, height, mem_pivot_h, mem_pivot_v}
//   gem_touch  per-gem player-contact pulse
//   exit_ok    player1/player2 at the door
//   restart    synchronous level restart pulse
//   addr       registered sprite-memory address
//   hit        1 when addr comes from an object, 0 when it is BG_ADDR
//   gems_left  number of uncollected gems
//   clear      level-complete flag
// -----------------------------------------------------------------------------
module map_layer #(
    parameter int NUM_OBJ = 16,
    parameter int NUM_GEM = 4,
    parameter int ADDR_W  = 17,
    parameter int MEM_W   = 320,
    parameter int BG_ADDR = 12900,
    localparam int IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
    localparam int CNT_W  = $clog2(NUM_GEM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [9:0]        vga_h,
    input  logic [9:0]        vga_v,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [60:0]       wr_data,
    input  logic [NUM_GEM-1:0] gem_touch,
    input  logic [1:0]        exit_ok,
    input  logic              restart,
    output logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [CNT_W-1:0]  gems_left,
    output logic              clear
);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, CLEAR = 2'd2} state_t;

    // ---------------- object table ----------------
    // Only the valid bits are reset; descriptor fields are plain storage.
    logic [NUM_OBJ-1:0] valid_reg;
    logic [9:0] pivot_h_reg [NUM_OBJ];
    logic [9:0] pivot_v_reg [NUM_OBJ];
    logic [9:0] width_reg   [NUM_OBJ];
    logic [9:0] height_reg  [NUM_OBJ];
    logic [9:0] mem_h_reg   [NUM_OBJ];
    logic [9:0] mem_v_reg   [NUM_OBJ];
    logic       wr_ok;

    assign wr_ok = wr_en && (32'(wr_idx) < NUM_OBJ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (wr_ok) begin
            valid_reg[wr_idx] <= wr_data[60];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            pivot_h_reg[wr_idx] <= wr_data[59:50];
            pivot_v_reg[wr_idx] <= wr_data[49:40];
            width_reg[wr_idx]   <= wr_data[39:30];
            height_reg[wr_idx]  <= wr_data[29:20];
            mem_h_reg[wr_idx]   <= wr_data[19:10];
            mem_v_reg[wr_idx]   <= wr_data[9:0];
        end
    end

    // ---------------- gem tracking ----------------
    logic [NUM_OBJ-1:0] mask;
    logic               gems_done;
    state_t             state_reg, state_next;

`ifdef MAP_LAYER_GEM_EN
    logic [NUM_GEM-1:0] collected_reg;
    logic [CNT_W-1:0]   gems_left_calc;

    // OR-ing the touch vector makes re-touching a collected gem a no-op and
    // lets several gems land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collected_reg <= '0;
        end else if (restart) begin
            collected_reg <= '0;
        end else if (state_reg == PLAY) begin
            collected_reg <= collected_reg | gem_touch;
        end
    end

    always_comb begin
        gems_left_calc = CNT_W'(NUM_GEM);
        for (int i = 0; i < NUM_GEM; i++) begin
            if (collected_reg[i]) begin
                gems_left_calc = gems_left_calc - CNT_W'(1);
            end
        end
    end

    assign gems_left = gems_left_calc;
    assign gems_done = (gems_left_calc == '0);

    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_mask
        if (gi < NUM_GEM) begin : g_gem
            assign mask[gi] = collected_reg[gi];
        end else begin : g_plain
            assign mask[gi] = 1'b0;
        end
    end
`else
    logic unused_gem_touch;
    assign unused_gem_touch = ^gem_touch;
    assign gems_left        = '0;
    assign gems_done        = 1'b1;
    assign mask             = '0;
`endif

    // ---------------- stage 1: hit vector ----------------
    logic [8:0]         h_in, v_in;
    logic [NUM_OBJ-1:0] hit_vec_next;
    logic               unused_lsb;

    assign h_in       = vga_h[9:1];
    assign v_in       = vga_v[9:1];
    assign unused_lsb = vga_h[0] ^ vga_v[0];

    // Bounds are compared at 11 bits so pivot+size never wraps.
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_hit
        assign hit_vec_next[gi] = valid_reg[gi] && !mask[gi]
            && ({2'b0, h_in} >= {1'b0, pivot_h_reg[gi]})
            && ({2'b0, h_in} <  ({1'b0, pivot_h_reg[gi]} + {1'b0, width_reg[gi]}))
            && ({2'b0, v_in} >= {1'b0, pivot_v_reg[gi]})
            && ({2'b0, v_in} <  ({1'b0, pivot_v_reg[gi]} + {1'b0, height_reg[gi]}));
    end

    logic [8:0]         h_reg, v_reg;
    logic [NUM_OBJ-1:0] hit_vec_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_reg       <= '0;
            v_reg       <= '0;
            hit_vec_reg <= '0;
        end else begin
            h_reg       <= h_in;
            v_reg       <= v_in;
            hit_vec_reg <= hit_vec_next;
        end
    end

    // ---------------- stage 2: priority select + address ----------------
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic [ADDR_W-1:0] addr_next;

    // Scanning downward leaves the lowest hitting index as the winner.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_vec_reg[i]) begin
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
        end
    end

    // Full 32-bit arithmetic, then truncation to the memory address width.
    always_comb begin
        addr_next = ADDR_W'(BG_ADDR);
        if (sel_any) begin
            addr_next = ADDR_W'(
                ({23'd0, h_reg} - {22'd0, pivot_h_reg[sel_idx]} + {22'd0, mem_h_reg[sel_idx]})
              + ({23'd0, v_reg} - {22'd0, pivot_v_reg[sel_idx]} + {22'd0, mem_v_reg[sel_idx]})
                * 32'(MEM_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= ADDR_W'(BG_ADDR);
            hit  <= 1'b0;
        end else begin
            addr <= addr_next;
            hit  <= sel_any;
        end
    end

    // ---------------- level FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // restart overrides every transition, including PLAY->CLEAR.
    always_comb begin
        state_next = state_reg;
        if (restart) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (en) state_next = PLAY;
                PLAY: begin
                    if (!en) begin
                        state_next = IDLE;
                    end else if (gems_done && exit_ok == 2'b11) begin
                        state_next = CLEAR;
                    end
                end
                CLEAR:   state_next = CLEAR;
                default: state_next = IDLE;
            endcase
        end
    end

    assign clear = (state_reg == CLEAR);

endmodule

// File: tb/tb_map_layer.sv
module tb_map_layer;

`ifdef MAP_LAYER_GEM_EN
    localparam bit GEM_ON = 1'b1;
`else
    localparam bit GEM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [9:0]  vga_h, vga_v;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [60:0] wr_data;
    logic [3:0]  gem_touch;
    logic [1:0]  exit_ok;
    logic        restart;
    logic [16:0] addr;
    logic        hit;
    logic [2:0]  gems_left;
    logic        clear;

    map_layer dut (
        .clk(clk), .rst(rst), .en(en), .vga_h(vga_h), .vga_v(vga_v),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .gem_touch(gem_touch), .exit_ok(exit_ok), .restart(restart),
        .addr(addr), .hit(hit), .gems_left(gems_left), .clear(clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: plain table of rectangles plus collected flags.
    bit       m_valid [16];
    int       m_ph [16], m_pv [16], m_w [16], m_ht [16], m_mh [16], m_mv [16];
    bit [3:0] m_coll;

    typedef struct {
        int vh;
        int vv;
        int ea;
        bit eh;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_left();
        return GEM_ON ? (4 - $countones(m_coll)) : 0;
    endfunction

    function automatic void model_pix(input int vh, input int vv, output int ea, output bit eh);
        int h, v;
        bit masked;
        h  = vh / 2;
        v  = vv / 2;
        ea = 12900;
        eh = 1'b0;
        for (int i = 0; i < 16; i++) begin
            masked = GEM_ON && (i < 4) && m_coll[i[1:0]];
            if (m_valid[i] && !masked && h >= m_ph[i] && h < m_ph[i] + m_w[i]
                && v >= m_pv[i] && v < m_pv[i] + m_ht[i]) begin
                ea = ((h - m_ph[i] + m_mh[i]) + (v - m_pv[i] + m_mv[i]) * 320) % 131072;
                eh = 1'b1;
                break;
            end
        end
    endfunction

    task automatic wr(input int idx, input bit vld, input int ph, input int pv,
                      input int w, input int ht, input int mh, input int mv);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_idx  = idx[3:0];
        wr_data = {vld, 10'(ph), 10'(pv), 10'(w), 10'(ht), 10'(mh), 10'(mv)};
        @(negedge clk);
        wr_en = 1'b0;
        m_valid[idx] = vld;
        m_ph[idx] = ph; m_pv[idx] = pv; m_w[idx] = w;
        m_ht[idx] = ht; m_mh[idx] = mh; m_mv[idx] = mv;
        $display("write slot=%0d valid=%0d ph=%0d pv=%0d w=%0d h=%0d mh=%0d mv=%0d",
                 idx, vld, ph, pv, w, ht, mh, mv);
    endtask

    task automatic apply_chk(input string name, input int vh, input int vv, input int ea, input bit eh);
        @(negedge clk);
        vga_h = vh[9:0];
        vga_v = vv[9:0];
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        $display("pixel %s vga=(%0d,%0d) addr=%0d hit=%0d exp_addr=%0d exp_hit=%0d",
                 name, vh, vv, addr, hit, ea, eh);
        chk({name, "_addr"}, 32'(addr), ea);
        chk({name, "_hit"}, 32'(hit), 32'(eh));
    endtask

    task automatic chk_pix(input string name, input int vh, input int vv);
        int ea;
        bit eh;
        model_pix(vh, vv, ea, eh);
        apply_chk(name, vh, vv, ea, eh);
    endtask

    task automatic touch(input bit [3:0] bits, input bit counts);
        gem_touch = bits;
        @(negedge clk);
        gem_touch = 4'b0;
        if (GEM_ON && counts) m_coll = m_coll | bits;
        $display("gem_touch=%b gems_left=%0d exp=%0d", bits, gems_left, exp_left());
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        m_coll = '0;
        @(negedge clk);
    endtask

    initial begin
        int ea;
        bit eh;
        int vh, vv;
        int q_a[$];
        bit q_h[$];

        vecs[0] = '{40, 370, 69820, 1'b1};
        vecs[1] = '{20, 364, 68850, 1'b1};
        vecs[2] = '{479, 379, 71319, 1'b1};
        vecs[3] = '{480, 370, 12900, 1'b0};
        vecs[4] = '{40, 380, 12900, 1'b0};
        vecs[5] = '{18, 370, 12900, 1'b0};
        vecs[6] = '{600, 400, 29428, 1'b1};
        vecs[7] = '{619, 419, 32317, 1'b1};
        vecs[8] = '{620, 400, 12900, 1'b0};

        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_ph[i] = 0; m_pv[i] = 0; m_w[i] = 0;
            m_ht[i] = 0; m_mh[i] = 0; m_mv[i] = 0;
        end
        m_coll = '0;

        rst = 1'b1; en = 1'b0; vga_h = '0; vga_v = '0; wr_en = 1'b0;
        wr_idx = '0; wr_data = '0; gem_touch = '0; exit_ok = '0; restart = 1'b0;

        #1;
        chk("reset_addr", 32'(addr), 12900);
        chk("reset_hit", 32'(hit), 0);
        chk("reset_clear", 32'(clear), 0);
        chk("reset_gems_left", 32'(gems_left), exp_left());
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk_pix("empty_a", 40, 370);
        chk_pix("empty_b", 600, 400);

        en = 1'b1;
        wr(0, 1, 10, 182, 230, 8, 50, 215);
        wr(5, 1, 300, 200, 10, 10, 500, 500);

        // latency: output must still show the previous pixel after one clock
        @(negedge clk); vga_h = 10'd0; vga_v = 10'd0;
        @(negedge clk); @(negedge clk);
        vga_h = 10'd40; vga_v = 10'd370;
        @(negedge clk);
        chk("latency_1clk_addr", 32'(addr), 12900);
        @(negedge clk);
        chk("latency_2clk_addr", 32'(addr), 69820);
        chk("latency_2clk_hit", 32'(hit), 1);

        for (int i = 0; i < 9; i++) begin
            apply_chk($sformatf("vec%0d", i), vecs[i].vh, vecs[i].vv, vecs[i].ea, vecs[i].eh);
        end

        // overlap priority and fall-through after invalidation
        wr(3, 1, 15, 180, 20, 20, 0, 0);
        apply_chk("prio_slot0", 40, 370, 69820, 1'b1);
        wr(0, 0, 10, 182, 230, 8, 50, 215);
        apply_chk("prio_slot3", 40, 370, 1605, 1'b1);
        wr(0, 1, 10, 182, 230, 8, 50, 215);
        wr(3, 0, 15, 180, 20, 20, 0, 0);
        apply_chk("restored", 40, 370, 69820, 1'b1);

        // gems
        do_restart();
        touch(4'b0101, 1'b1);
        chk("gems_first_touch", 32'(gems_left), GEM_ON ? 2 : 0);
        touch(4'b0101, 1'b1);
        chk("gems_repeat_touch", 32'(gems_left), GEM_ON ? 2 : 0);
        apply_chk("gem0_pixel", 40, 370, GEM_ON ? 12900 : 69820, GEM_ON ? 1'b0 : 1'b1);

        en = 1'b0;
        @(negedge clk);
        touch(4'b0010, 1'b0);
        chk("gems_idle_ignored", 32'(gems_left), exp_left());
        en = 1'b1;
        @(negedge clk);
        touch(4'b1010, 1'b1);
        chk("gems_all", 32'(gems_left), 0);
        chk("clear_before_exit", 32'(clear), 0);
        exit_ok = 2'b11;
        @(negedge clk);
        exit_ok = 2'b00;
        $display("exit clear=%0d", clear);
        chk("clear_set", 32'(clear), 1);
        @(negedge clk);
        chk("clear_held", 32'(clear), 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        m_coll = '0;
        chk("restart_clear", 32'(clear), 0);
        chk("restart_gems", 32'(gems_left), GEM_ON ? 4 : 0);

        @(negedge clk);
        touch(4'b1111, 1'b1);
        chk("gems_all_again", 32'(gems_left), 0);
        exit_ok = 2'b11;
        restart = 1'b1;
        @(negedge clk);
        exit_ok = 2'b00;
        restart = 1'b0;
        m_coll = '0;
        $display("restart+exit clear=%0d gems_left=%0d", clear, gems_left);
        chk("restart_wins_clear", 32'(clear), 0);
        chk("restart_wins_gems", 32'(gems_left), GEM_ON ? 4 : 0);
        @(negedge clk);
        chk("restart_wins_clear_later", 32'(clear), 0);

        // randomized table and pixel stream against the model
        do_restart();
        for (int i = 0; i < 16; i++) begin
            wr(i, $urandom_range(0, 3) != 0, $urandom_range(0, 299), $urandom_range(0, 219),
               $urandom_range(1, 80), $urandom_range(1, 80),
               $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        touch(4'($urandom_range(0, 15)), 1'b1);
        chk("rand_gems_left", 32'(gems_left), exp_left());
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (q_a.size() == 2) begin
                ea = q_a.pop_front();
                eh = q_h.pop_front();
                $display("rand %0d addr=%0d hit=%0d exp_addr=%0d exp_hit=%0d", n, addr, hit, ea, eh);
                chk("rand_addr", 32'(addr), ea);
                chk("rand_hit", 32'(hit), 32'(eh));
            end
            vh = $urandom_range(0, 639);
            vv = $urandom_range(0, 479);
            model_pix(vh, vv, ea, eh);
            q_a.push_back(ea);
            q_h.push_back(eh);
            vga_h = vh[9:0];
            vga_v = vv[9:0];
        end

        // asynchronous reset in the middle of a hitting pipeline
        do_restart();
        wr(0, 1, 10, 182, 230, 8, 50, 215);
        @(negedge clk);
        vga_h = 10'd40; vga_v = 10'd370;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_hit", 32'(hit), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_coll = '0;
        $display("async rst addr=%0d hit=%0d", addr, hit);
        chk("async_rst_addr", 32'(addr), 12900);
        chk("async_rst_hit", 32'(hit), 0);
        chk("async_rst_clear", 32'(clear), 0);
        chk("async_rst_gems", 32'(gems_left), exp_left());
        @(negedge clk);
        rst = 1'b0;
        chk_pix("after_rst_a", 40, 370);
        chk_pix("after_rst_b", 600, 400);
        for (int i = 0; i < 4; i++) begin
            chk_pix("after_rst_rand", $urandom_range(0, 639), $urandom_range(0, 479));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
